codificador_inmediato: RTL and testbench



---
 rtl/codificador_inmediato.sv | 109 ++++++++++
 tb/tb_codificador_inmediato.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/codificador_inmediato.sv
// Immediate encoder: inverse of the immediate extension unit. Checks whether a
// 32-bit constant fits the requested ExtImm format and packs the 24-bit field.
module codificador_inmediato #(
    parameter int NROT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] dataI,
    input  logic [1:0]  ExtImm,
    output logic [23:0] dataO,
    output logic        ok,
    output logic        done,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, SEARCH, FIN} state_t;

    localparam logic [3:0] ROT_LAST = 4'(NROT - 1);

    state_t      state_q, state_d;
    logic [31:0] val_q;
    logic [1:0]  mode_q;
    logic [3:0]  rot_q;
    logic [23:0] dataO_q;
    logic        ok_q;

    logic [5:0]  sh;
    logic [31:0] cand;
    logic        eval_ok, eval_fin;
    logic [23:0] eval_data;

    // Rotate-left by 2*rot; a right shift by 32 yields 0, so rot=0 is plain val.
    assign sh   = {1'b0, rot_q, 1'b0};
    assign cand = (val_q << sh) | (val_q >> (6'd32 - sh));

    // Evaluation of the current SEARCH cycle. Linear modes resolve in one pass.
    always_comb begin
        eval_ok   = 1'b0;
        eval_fin  = 1'b1;
        eval_data = '0;
        case (mode_q)
            2'b00: begin
                eval_ok   = (val_q[31:24] == 8'h00);
                eval_data = val_q[23:0];
            end
            2'b01: begin
                eval_ok   = (&val_q[31:23]) | ~(|val_q[31:23]);
                eval_data = val_q[23:0];
            end
            2'b10: begin
                eval_ok   = (&val_q[31:11]) | ~(|val_q[31:11]);
                eval_data = {12'b0, val_q[11:0]};
            end
            default: begin
                eval_ok   = (cand[31:8] == 24'h0);
                eval_fin  = eval_ok | (rot_q == ROT_LAST);
                eval_data = {12'b0, rot_q, cand[7:0]};
            end
        endcase
        if (!eval_ok) eval_data = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)    state_d = SEARCH;
            SEARCH:  if (eval_fin) state_d = FIN;
            FIN:                   state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    always_comb begin
        done = (state_q == FIN);
        busy = (state_q != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_q   <= '0;
            mode_q  <= '0;
            rot_q   <= '0;
            dataO_q <= '0;
            ok_q    <= 1'b0;
        end else begin
            if (state_q == IDLE && start) begin
                val_q  <= dataI;
                mode_q <= ExtImm;
                rot_q  <= '0;
            end
            if (state_q == SEARCH) begin
                if (eval_fin) begin
                    dataO_q <= eval_data;
                    ok_q    <= eval_ok;
                end else begin
                    rot_q <= rot_q + 4'd1;
                end
            end
        end
    end

    assign dataO = dataO_q;
    assign ok    = ok_q;
endmodule

// File: tb/tb_codificador_inmediato.sv
// Self-checking bench for codificador_inmediato: directed plan cases plus
// randomized requests checked against a range/rotation reference model.
module tb_codificador_inmediato;
    localparam int NROT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] dataI;
    logic [1:0]  ExtImm;
    logic [23:0] dataO;
    logic        ok, done, busy;

    int checks = 0;
    int errors = 0;

    codificador_inmediato #(.NROT(NROT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dataI(dataI), .ExtImm(ExtImm),
        .dataO(dataO), .ok(ok), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: representability by numeric range; mode 11 tries every even rotation.
    function automatic void model(input logic [31:0] v, input logic [1:0] m,
                                  output logic eok, output logic [23:0] ed, output int elat);
        int sv;
        logic [63:0] dbl;
        logic [31:0] c;
        bit found;
        eok = 1'b0; ed = '0; elat = 1; sv = int'(v);
        case (m)
            2'd0: if (v < 32'h0100_0000) begin eok = 1'b1; ed = v[23:0]; end
            2'd1: if (sv >= -(1 << 23) && sv < (1 << 23)) begin eok = 1'b1; ed = v[23:0]; end
            2'd2: if (sv >= -2048 && sv <= 2047) begin eok = 1'b1; ed = {12'b0, v[11:0]}; end
            default: begin
                found = 0;
                elat  = NROT;
                for (int r = 0; r < NROT; r++) begin
                    dbl = {v, v} >> (32 - 2 * r);
                    c   = dbl[31:0];
                    if (!found && c < 32'd256) begin
                        found = 1;
                        eok   = 1'b1;
                        ed    = 24'(r * 256 + int'(c));
                        elat  = r + 1;
                    end
                end
            end
        endcase
    endfunction

    task automatic do_req(input logic [31:0] v, input logic [1:0] m,
                          input bit use_poke, input logic [31:0] poke);
        logic eok;
        logic [23:0] ed;
        int elat, n;
        bit seen;
        model(v, m, eok, ed, elat);
        @(negedge clk);
        dataI = v; ExtImm = m; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; dataI = $urandom; ExtImm = 2'($urandom);
        chk("busy_after_E0", 32'(busy), 32'd1);
        n = 0; seen = 0;
        while (!seen && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (use_poke && n == 3) begin start = 1'b1; dataI = poke; ExtImm = 2'b11; end
            else if (use_poke && n == 4) start = 1'b0;
            if (done) seen = 1;
            else if (use_poke) chk("busy_during_search", 32'(busy), 32'd1);
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("latency", 32'(n), 32'(elat));
        chk("ok", 32'(ok), 32'(eok));
        chk("dataO", 32'(dataO), 32'(ed));
        chk("busy_at_done", 32'(busy), 32'd1);
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("busy_released", 32'(busy), 32'd0);
        chk("dataO_hold", 32'(dataO), 32'(ed));
        chk("ok_hold", 32'(ok), 32'(eok));
        if (use_poke) begin
            @(posedge clk); #1;
            chk("no_second_done", 32'(done), 32'd0);
        end
    endtask

    initial begin
        bit done_seen;
        logic [31:0] v;
        logic [1:0]  m;
        rst_n = 1'b0; start = 1'b0; dataI = '0; ExtImm = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dataO", 32'(dataO), 32'd0);
        chk("rst_ok", 32'(ok), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        do_req(32'h00AB_CDEF, 2'b00, 0, 0);
        chk("plan_00_data", 32'(dataO), 32'h00AB_CDEF);
        do_req(32'h0100_0000, 2'b00, 0, 0);
        do_req(32'hFF80_0000, 2'b01, 0, 0);
        chk("plan_01_data", 32'(dataO), 32'h0080_0000);
        do_req(32'hFF00_0000, 2'b01, 0, 0);
        do_req(32'hFFFF_F800, 2'b10, 0, 0);
        chk("plan_10_data", 32'(dataO), 32'h0000_0800);
        do_req(32'h0000_0800, 2'b10, 0, 0);
        do_req(32'h0000_00FF, 2'b11, 0, 0);
        do_req(32'hFF00_0000, 2'b11, 0, 0);
        chk("plan_rot4", 32'(dataO), 32'h0000_04FF);
        do_req(32'h0000_03FC, 2'b11, 0, 0);
        chk("plan_rot15", 32'(dataO), 32'h0000_0FFF);
        do_req(32'h0000_0000, 2'b11, 0, 0);
        do_req(32'h0000_0102, 2'b11, 1, 32'h0000_00FF);

        // Abort: leave a known nonzero result, then reset in the middle of a search.
        do_req(32'h0000_00FF, 2'b11, 0, 0);
        @(negedge clk);
        dataI = 32'h0000_0102; ExtImm = 2'b11; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("hold_mid_search", 32'(dataO), 32'h0000_00FF);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        chk("abort_dataO", 32'(dataO), 32'd0);
        chk("abort_ok", 32'(ok), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        done_seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done) done_seen = 1;
        end
        chk("abort_no_done", 32'(done_seen), 32'd0);
        do_req(32'h0000_00FF, 2'b11, 0, 0);
        chk("after_abort_data", 32'(dataO), 32'h0000_00FF);

        for (int i = 0; i < 40; i++) begin
            m = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: v = $urandom;
                1: v = 32'($signed(12'($urandom)));
                2: v = 32'($signed(24'($urandom)));
                default: begin
                    v = 32'($urandom_range(0, 255));
                    v = (v << (2 * $urandom_range(0, 15))) | (v >> (32 - 2 * $urandom_range(0, 15)));
                end
            endcase
            do_req(v, m, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
